sim_host_sequencer: RTL and testbench

- Upstream driver for the simulation host path. Consumes a 32-bit word stream from a testbench FIFO or file reader, frames it into Nysa host commands, and drives the sim_in_* handshake of the sim host interface one data word at a time.
- Captures sim_out_* responses into a one-entry buffer and serialises them as a 4-word response stream.
- Makes command-level testbenches cycle-accurate and repeatable.

---
 rtl/sim_host_sequencer_pkg.sv | 27 ++
 rtl/sim_host_sequencer_resp.sv | 73 +++++++
 rtl/sim_host_sequencer.sv | 117 +++++++++++
 tb/tb_sim_host_sequencer.sv | 296 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/sim_host_sequencer_pkg.sv
// Shared types and constants for the simulation host sequencer slice.
package sim_host_sequencer_pkg;

    localparam int unsigned COUNT_W    = 28;
    localparam int unsigned RESP_WORDS = 4;

    typedef enum logic [2:0] {
        IDLE,
        HDR_CNT,
        HDR_ADDR,
        DATA_WAIT,
        ISSUE,
        HOLD,
        BUS_RST
    } cmd_state_t;

    typedef enum logic {
        R_IDLE,
        R_DRAIN
    } resp_state_t;

    // A zero count still carries one data word.
    function automatic logic [COUNT_W-1:0] frame_len(input logic [COUNT_W-1:0] cnt);
        return (cnt == '0) ? COUNT_W'(1) : cnt;
    endfunction

endpackage

// File: rtl/sim_host_sequencer_resp.sv
// Response latch, 4-word drain FSM and sticky overflow flag.
module sim_resp_serializer
    import sim_host_sequencer_pkg::*;
(
    input  logic               clk,
    input  logic               rst,
    input  logic               i_sim_out_en,
    input  logic [31:0]        i_sim_out_status,
    input  logic [31:0]        i_sim_out_address,
    input  logic [31:0]        i_sim_out_data,
    input  logic [COUNT_W-1:0] i_sim_out_data_count,
    output logic               o_sim_out_ready,
    output logic               o_out_valid,
    input  logic               i_out_ready,
    output logic [31:0]        o_out_word,
    output logic               o_overflow
);

    resp_state_t        state, state_nxt;
    logic [1:0]         idx;
    logic [31:0]        r_status, r_address, r_data;
    logic [COUNT_W-1:0] r_count;
    logic               fire;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= R_IDLE;
        else     state <= state_nxt;
    end

    always_comb begin
        state_nxt       = state;
        o_out_valid     = (state == R_DRAIN);
        o_sim_out_ready = (state == R_IDLE) && !rst;
        fire            = o_out_valid && i_out_ready;
        o_out_word      = '0;
        if (o_out_valid) begin
            case (idx)
                2'd0:    o_out_word = r_status;
                2'd1:    o_out_word = r_address;
                2'd2:    o_out_word = r_data;
                default: o_out_word = {4'h0, r_count};
            endcase
        end
        case (state)
            R_IDLE:  if (i_sim_out_en) state_nxt = R_DRAIN;
            R_DRAIN: if (fire && idx == 2'(RESP_WORDS - 1)) state_nxt = R_IDLE;
            default: state_nxt = R_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            idx        <= '0;
            r_status   <= '0;
            r_address  <= '0;
            r_data     <= '0;
            r_count    <= '0;
            o_overflow <= 1'b0;
        end else if (state == R_IDLE) begin
            if (i_sim_out_en) begin
                idx       <= '0;
                r_status  <= i_sim_out_status;
                r_address <= i_sim_out_address;
                r_data    <= i_sim_out_data;
                r_count   <= i_sim_out_data_count;
            end
        end else begin
            if (i_sim_out_en) o_overflow <= 1'b1;
            if (fire)         idx <= idx + 2'd1;
        end
    end

endmodule

// File: rtl/sim_host_sequencer.sv
// Frames a 32-bit word stream into Nysa host commands and drives the sim host handshake.
module sim_host_sequencer #(
    parameter int unsigned HOLDOFF      = 2,
    parameter int unsigned RESET_CYCLES = 4
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        i_host_reset_req,
    input  logic        i_in_valid,
    output logic        o_in_ready,
    input  logic [31:0] i_in_word,
    output logic        o_sim_in_reset,
    output logic        o_sim_in_ready,
    output logic [31:0] o_sim_in_command,
    output logic [31:0] o_sim_in_address,
    output logic [31:0] o_sim_in_data,
    output logic [31:0] o_sim_in_data_count,
    input  logic        i_sim_master_ready,
    output logic        o_sim_out_ready,
    input  logic        i_sim_out_en,
    input  logic [31:0] i_sim_out_status,
    input  logic [31:0] i_sim_out_address,
    input  logic [31:0] i_sim_out_data,
    input  logic [27:0] i_sim_out_data_count,
    output logic        o_out_valid,
    input  logic        i_out_ready,
    output logic [31:0] o_out_word,
    output logic        o_overflow
);
    import sim_host_sequencer_pkg::*;

    cmd_state_t         state, state_nxt;
    logic [COUNT_W-1:0] remaining;
    logic [3:0]         hold_cnt;
    logic [7:0]         rst_cnt;
    logic               accept;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= IDLE;
        else     state <= state_nxt;
    end

    always_comb begin
        state_nxt      = state;
        o_in_ready     = ((state == IDLE) || (state == HDR_CNT) || (state == HDR_ADDR) ||
                          (state == DATA_WAIT)) && !i_host_reset_req && !rst;
        accept         = o_in_ready && i_in_valid;
        o_sim_in_ready = (state == ISSUE) && i_sim_master_ready && !i_host_reset_req;
        o_sim_in_reset = (state == BUS_RST);
        if (i_host_reset_req) begin
            state_nxt = BUS_RST;
        end else begin
            case (state)
                IDLE:      if (accept) state_nxt = HDR_CNT;
                HDR_CNT:   if (accept) state_nxt = HDR_ADDR;
                HDR_ADDR:  if (accept) state_nxt = DATA_WAIT;
                DATA_WAIT: if (accept) state_nxt = ISSUE;
                ISSUE:     if (o_sim_in_ready) state_nxt = HOLD;
                HOLD:      if (hold_cnt == '0) state_nxt = (remaining != '0) ? DATA_WAIT : IDLE;
                BUS_RST:   if (rst_cnt == '0) state_nxt = IDLE;
                default:   state_nxt = IDLE;
            endcase
        end
    end

    // Hold and reset counters are preloaded with length-1 so the state lasts exactly that many cycles.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            remaining           <= '0;
            hold_cnt            <= '0;
            rst_cnt             <= '0;
            o_sim_in_command    <= '0;
            o_sim_in_address    <= '0;
            o_sim_in_data       <= '0;
            o_sim_in_data_count <= '0;
        end else if (i_host_reset_req) begin
            remaining <= '0;
            rst_cnt   <= 8'(RESET_CYCLES - 1);
        end else begin
            if (accept) begin
                case (state)
                    IDLE:      o_sim_in_command <= i_in_word;
                    HDR_CNT: begin
                        o_sim_in_data_count <= {4'h0, i_in_word[COUNT_W-1:0]};
                        remaining           <= frame_len(i_in_word[COUNT_W-1:0]);
                    end
                    HDR_ADDR:  o_sim_in_address <= i_in_word;
                    DATA_WAIT: o_sim_in_data    <= i_in_word;
                    default: ;
                endcase
            end
            if (o_sim_in_ready) begin
                remaining <= remaining - COUNT_W'(1);
                hold_cnt  <= 4'(HOLDOFF - 1);
            end else if (state == HOLD && hold_cnt != '0) begin
                hold_cnt <= hold_cnt - 4'd1;
            end
            if (state == BUS_RST && rst_cnt != '0) rst_cnt <= rst_cnt - 8'd1;
        end
    end

    sim_resp_serializer u_resp (
        .clk                  (clk),
        .rst                  (rst),
        .i_sim_out_en         (i_sim_out_en),
        .i_sim_out_status     (i_sim_out_status),
        .i_sim_out_address    (i_sim_out_address),
        .i_sim_out_data       (i_sim_out_data),
        .i_sim_out_data_count (i_sim_out_data_count),
        .o_sim_out_ready      (o_sim_out_ready),
        .o_out_valid          (o_out_valid),
        .i_out_ready          (i_out_ready),
        .o_out_word           (o_out_word),
        .o_overflow           (o_overflow)
    );

endmodule

// File: tb/tb_sim_host_sequencer.sv
// Scoreboard bench: frame/response model queues checked by a negedge monitor.
module tb_sim_host_sequencer;

    localparam int unsigned HOLDOFF      = 2;
    localparam int unsigned RESET_CYCLES = 4;
    localparam int          TMO          = 2000;

    logic        clk, rst;
    logic        i_host_reset_req, i_in_valid, o_in_ready;
    logic [31:0] i_in_word;
    logic        o_sim_in_reset, o_sim_in_ready;
    logic [31:0] o_sim_in_command, o_sim_in_address, o_sim_in_data, o_sim_in_data_count;
    logic        i_sim_master_ready, o_sim_out_ready, i_sim_out_en;
    logic [31:0] i_sim_out_status, i_sim_out_address, i_sim_out_data;
    logic [27:0] i_sim_out_data_count;
    logic        o_out_valid, i_out_ready;
    logic [31:0] o_out_word;
    logic        o_overflow;

    bit mr_auto, mr_force, mr_rnd, or_auto, or_force, or_rnd;
    assign i_sim_master_ready = mr_auto ? mr_rnd : mr_force;
    assign i_out_ready        = or_auto ? or_rnd : or_force;

    int tests = 0, fails = 0;
    int pulses = 0, rst_hi = 0, cyc = 0, last_pulse = -1000;
    logic [127:0] in_q[$];
    logic [31:0]  r_q[$];
    logic [31:0]  cur_cmd, cur_addr, cur_cnt;

    sim_host_sequencer #(.HOLDOFF(HOLDOFF), .RESET_CYCLES(RESET_CYCLES)) dut (
        .clk(clk), .rst(rst), .i_host_reset_req(i_host_reset_req),
        .i_in_valid(i_in_valid), .o_in_ready(o_in_ready), .i_in_word(i_in_word),
        .o_sim_in_reset(o_sim_in_reset), .o_sim_in_ready(o_sim_in_ready),
        .o_sim_in_command(o_sim_in_command), .o_sim_in_address(o_sim_in_address),
        .o_sim_in_data(o_sim_in_data), .o_sim_in_data_count(o_sim_in_data_count),
        .i_sim_master_ready(i_sim_master_ready), .o_sim_out_ready(o_sim_out_ready),
        .i_sim_out_en(i_sim_out_en), .i_sim_out_status(i_sim_out_status),
        .i_sim_out_address(i_sim_out_address), .i_sim_out_data(i_sim_out_data),
        .i_sim_out_data_count(i_sim_out_data_count), .o_out_valid(o_out_valid),
        .i_out_ready(i_out_ready), .o_out_word(o_out_word), .o_overflow(o_overflow)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) begin
        #1;
        mr_rnd = ($urandom_range(0, 3) != 0);
        or_rnd = ($urandom_range(0, 2) != 0);
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Monitor: every handshake the DUT presents is matched against the model queues.
    always @(negedge clk) begin
        logic [127:0] e;
        logic [31:0]  w;
        cyc++;
        if (!rst) begin
            if (o_sim_in_reset) rst_hi++;
            if (o_sim_in_ready) begin
                pulses++;
                chk("pulse_master_ready", 32'(i_sim_master_ready), 32'd1);
                chk("pulse_spacing", 32'(cyc - last_pulse >= int'(HOLDOFF) + 1), 32'd1);
                last_pulse = cyc;
                chk("pulse_expected", 32'(in_q.size()), 32'd1);
                if (in_q.size() > 0) begin
                    e = in_q.pop_front();
                    chk("sim_in_command", o_sim_in_command, e[127:96]);
                    chk("sim_in_address", o_sim_in_address, e[95:64]);
                    chk("sim_in_data", o_sim_in_data, e[63:32]);
                    chk("sim_in_data_count", o_sim_in_data_count, e[31:0]);
                end
            end
            chk("sim_out_ready", 32'(o_sim_out_ready), 32'(r_q.size() == 0));
            if (o_out_valid && i_out_ready) begin
                chk("resp_expected", 32'(r_q.size() > 0), 32'd1);
                if (r_q.size() > 0) begin
                    w = r_q.pop_front();
                    chk("resp_word", o_out_word, w);
                end
            end
        end
    end

    task automatic send_word(input logic [31:0] w);
        int t = 0;
        @(posedge clk); #1;
        i_in_valid = 1'b1;
        i_in_word  = w;
        forever begin
            @(negedge clk);
            if (o_in_ready) break;
            t++;
            if (t > TMO) break;
        end
        if (t > TMO) chk("in_ready_timeout", 32'(o_in_ready), 32'd1);
        @(posedge clk); #1;
        i_in_valid = 1'b0;
    endtask

    task automatic send_header(input logic [31:0] cmd, input logic [31:0] cntw, input logic [31:0] addr);
        send_word(cmd);
        send_word(cntw);
        send_word(addr);
        cur_cmd  = cmd;
        cur_addr = addr;
        cur_cnt  = {4'h0, cntw[27:0]};
    endtask

    task automatic send_data(input logic [31:0] d);
        send_word(d);
        in_q.push_back({cur_cmd, cur_addr, d, cur_cnt});
    endtask

    task automatic wait_pulses(input int target, input string name);
        int t = 0;
        while (pulses < target && t < TMO) begin
            @(negedge clk);
            t++;
        end
        chk(name, 32'(pulses >= target), 32'd1);
    endtask

    task automatic send_resp(input logic [31:0] st, input logic [31:0] ad, input logic [31:0] da,
                             input logic [27:0] cn);
        int t = 0;
        forever begin
            @(negedge clk);
            if (o_sim_out_ready || t > TMO) break;
            t++;
        end
        if (t > TMO) chk("out_ready_timeout", 32'(o_sim_out_ready), 32'd1);
        i_sim_out_en         = 1'b1;
        i_sim_out_status     = st;
        i_sim_out_address    = ad;
        i_sim_out_data       = da;
        i_sim_out_data_count = cn;
        @(posedge clk); #1;
        i_sim_out_en = 1'b0;
        r_q.push_back(st);
        r_q.push_back(ad);
        r_q.push_back(da);
        r_q.push_back({4'h0, cn});
    endtask

    task automatic wait_resp_drained(input string name);
        int t = 0;
        while (r_q.size() != 0 && t < TMO) begin
            @(negedge clk);
            t++;
        end
        chk(name, 32'(r_q.size()), 32'd0);
    endtask

    initial begin
        int p0, r0, n, total;
        rst = 1'b1;
        i_host_reset_req = 1'b0; i_in_valid = 1'b0; i_in_word = '0;
        i_sim_out_en = 1'b0; i_sim_out_status = '0; i_sim_out_address = '0;
        i_sim_out_data = '0; i_sim_out_data_count = '0;
        mr_auto = 1'b0; mr_force = 1'b1; or_auto = 1'b0; or_force = 1'b1;

        repeat (3) @(negedge clk);
        chk("rst_in_ready", 32'(o_in_ready), 32'd0);
        chk("rst_sim_in_ready", 32'(o_sim_in_ready), 32'd0);
        chk("rst_sim_in_reset", 32'(o_sim_in_reset), 32'd0);
        chk("rst_command", o_sim_in_command, 32'd0);
        chk("rst_address", o_sim_in_address, 32'd0);
        chk("rst_data", o_sim_in_data, 32'd0);
        chk("rst_data_count", o_sim_in_data_count, 32'd0);
        chk("rst_sim_out_ready", 32'(o_sim_out_ready), 32'd0);
        chk("rst_out_valid", 32'(o_out_valid), 32'd0);
        chk("rst_out_word", o_out_word, 32'd0);
        chk("rst_overflow", 32'(o_overflow), 32'd0);
        @(posedge clk); #1;
        rst = 1'b0;

        // Single-word frame
        p0 = pulses;
        send_header(32'h1, 32'h1, 32'h100);
        send_data(32'hDEADBEEF);
        wait_pulses(p0 + 1, "t1_pulse");
        repeat (10) @(negedge clk);
        chk("t1_pulse_count", 32'(pulses - p0), 32'd1);
        chk("t1_data_hold", o_sim_in_data, 32'hDEADBEEF);

        // Three words, master stalls before the second
        p0 = pulses;
        send_header(32'h2, 32'h3, 32'h200);
        send_data(32'hAAAA0001);
        wait_pulses(p0 + 1, "t2_first");
        mr_force = 1'b0;
        send_data(32'hBBBB0002);
        repeat (5) @(posedge clk);
        #1;
        chk("t2_stalled", 32'(pulses - p0), 32'd1);
        mr_force = 1'b1;
        send_data(32'hCCCC0003);
        wait_pulses(p0 + 3, "t2_all");
        repeat (10) @(negedge clk);
        chk("t2_pulse_count", 32'(pulses - p0), 32'd3);

        // Zero count with junk in the top nibble
        p0 = pulses;
        send_header(32'h3, 32'hF0000000, 32'h300);
        send_data($urandom);
        wait_pulses(p0 + 1, "t3_pulse");
        repeat (10) @(negedge clk);
        chk("t3_pulse_count", 32'(pulses - p0), 32'd1);
        chk("t3_data_count", o_sim_in_data_count, 32'd0);

        // Random frames, random master backpressure
        mr_auto = 1'b1;
        p0 = pulses;
        total = 0;
        for (int f = 0; f < 6; f++) begin
            n = $urandom_range(1, 4);
            send_header($urandom, {4'($urandom), 28'(n)}, $urandom);
            for (int k = 0; k < n; k++) send_data($urandom);
            total += n;
        end
        wait_pulses(p0 + total, "t4_all");
        mr_auto = 1'b0;
        mr_force = 1'b1;

        // Host reset mid-burst, with a colliding word offered
        p0 = pulses;
        send_header(32'h5, 32'h4, 32'h500);
        send_data(32'h11111111);
        send_data(32'h22222222);
        wait_pulses(p0 + 2, "t5_two");
        r0 = rst_hi;
        @(posedge clk); #1;
        i_host_reset_req = 1'b1;
        i_in_valid = 1'b1;
        i_in_word = 32'hBADBAD00;
        @(negedge clk);
        chk("t5_in_ready_blocked", 32'(o_in_ready), 32'd0);
        @(posedge clk); #1;
        i_host_reset_req = 1'b0;
        i_in_valid = 1'b0;
        repeat (15) @(negedge clk);
        chk("t5_reset_width", 32'(rst_hi - r0), 32'(RESET_CYCLES));
        chk("t5_no_more_pulses", 32'(pulses - p0), 32'd2);
        p0 = pulses;
        send_header(32'h6, 32'h1, 32'h600);
        send_data(32'h66666666);
        wait_pulses(p0 + 1, "t5_next_frame");

        // Response with sink stall
        or_force = 1'b0;
        send_resp(32'h2, 32'h10, 32'h55, 28'h1);
        repeat (3) @(posedge clk);
        #1;
        or_force = 1'b1;
        wait_resp_drained("t6_drained");
        chk("t6_no_overflow", 32'(o_overflow), 32'd0);

        // Second strobe while draining is dropped
        or_force = 1'b0;
        send_resp(32'hA1, 32'hA2, 32'hA3, 28'h0ABCDEF);
        i_sim_out_en = 1'b1;
        i_sim_out_status = 32'hE1;
        i_sim_out_address = 32'hE2;
        i_sim_out_data = 32'hE3;
        i_sim_out_data_count = 28'h7;
        @(posedge clk); #1;
        i_sim_out_en = 1'b0;
        @(negedge clk);
        chk("t7_overflow", 32'(o_overflow), 32'd1);
        chk("t7_first_word", o_out_word, 32'hA1);
        or_force = 1'b1;
        wait_resp_drained("t7_drained");
        chk("t7_overflow_sticky", 32'(o_overflow), 32'd1);

        // Random responses, random sink backpressure
        or_auto = 1'b1;
        for (int k = 0; k < 5; k++)
            send_resp($urandom, $urandom, $urandom, 28'($urandom));
        wait_resp_drained("t8_drained");
        or_auto = 1'b0;

        repeat (5) @(negedge clk);
        chk("final_in_q_empty", 32'(in_q.size()), 32'd0);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
